ctrl_entrada_teclado: RTL and testbench

- Entry sequencer between the 4x4 keypad scan driver and the application logic.
- Debounces the driver's key-active level and accepts exactly one event per physical press.
- Assembles decimal keys into an NDIG-digit BCD entry buffer; handles clear (F), enter (E) and command keys (A-D).
- Issues one-cycle strobes for completed entries and commands; runs at the keypad scan clock (100 Hz).

---
 rtl/ctrl_entrada_teclado.sv | 162 ++++++++++++++++
 tb/tb_ctrl_entrada_teclado.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_entrada_teclado.sv
// Keypad entry sequencer: debounces key_act, accepts one event per press and
// assembles decimal digits into a BCD entry buffer with enter/clear/command keys.
module ctrl_entrada_teclado #(
    parameter int unsigned NDIG = 3,
    parameter int unsigned DEB  = 3,
    parameter int unsigned TMO  = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        key_code,
    input  logic              key_act,
    output logic [4*NDIG-1:0] buf_bcd,
    output logic [3:0]        buf_cnt,
    output logic [4*NDIG-1:0] val_bcd,
    output logic              val_stb,
    output logic [1:0]        cmd,
    output logic              cmd_stb,
    output logic              ovf
);

    localparam int unsigned BW = 4 * NDIG;
    localparam int unsigned TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StPDeb,
        StAccept,
        StHeld,
        StRDeb
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [BW-1:0]   val_q, val_d;
    logic [1:0]      cmd_q, cmd_d;
    logic            val_stb_q, val_stb_d;
    logic            cmd_stb_q, cmd_stb_d;
    logic            ovf_q, ovf_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            buf_q     <= '0;
            bcnt_q    <= '0;
            val_q     <= '0;
            cmd_q     <= '0;
            val_stb_q <= 1'b0;
            cmd_stb_q <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            bcnt_q    <= bcnt_d;
            val_q     <= val_d;
            cmd_q     <= cmd_d;
            val_stb_q <= val_stb_d;
            cmd_stb_q <= cmd_stb_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        bcnt_d    = bcnt_q;
        val_d     = val_q;
        cmd_d     = cmd_q;
        val_stb_d = 1'b0;
        cmd_stb_d = 1'b0;
        ovf_d     = 1'b0;
        tmo_d     = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (key_act) begin
                    state_d = StPDeb;
                    cnt_d   = 4'd1;
                end
            end
            StPDeb: begin
                if (!key_act) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'(DEB)) begin
                    state_d = StAccept;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAccept: begin
                state_d = StHeld;
                if (key_code < 5'd10) begin
                    if (bcnt_q < 4'(NDIG)) begin
                        buf_d  = (buf_q << 4) | BW'(key_code[3:0]);
                        bcnt_d = bcnt_q + 4'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (key_code <= 5'd13) begin
                    // A..D map to 0..3: low two bits plus 2 wraps mod 4
                    cmd_d     = key_code[1:0] + 2'd2;
                    cmd_stb_d = 1'b1;
                end else if (key_code == 5'd14) begin
                    if (bcnt_q != 4'd0) begin
                        val_d     = buf_q;
                        val_stb_d = 1'b1;
                        buf_d     = '0;
                        bcnt_d    = '0;
                    end
                end else if (key_code == 5'd15) begin
                    buf_d  = '0;
                    bcnt_d = '0;
                end
            end
            StHeld: begin
                if (!key_act) begin
                    state_d = StRDeb;
                    cnt_d   = 4'd1;
                end
            end
            StRDeb: begin
                if (key_act) begin
                    state_d = StHeld;
                end else if (cnt_q == 4'(DEB)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Partial entries left idle too long are dropped without a strobe
        if (state_q == StAccept || bcnt_q == 4'd0) begin
            tmo_d = '0;
        end else if (TMO != 0 && state_q == StIdle) begin
            if (tmo_q == TW'(TMO - 1)) begin
                tmo_d  = '0;
                buf_d  = '0;
                bcnt_d = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign buf_bcd = buf_q;
    assign buf_cnt = bcnt_q;
    assign val_bcd = val_q;
    assign val_stb = val_stb_q;
    assign cmd     = cmd_q;
    assign cmd_stb = cmd_stb_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_ctrl_entrada_teclado.sv
// Directed bench for ctrl_entrada_teclado (NDIG=3, DEB=3, TMO=20).
module tb_ctrl_entrada_teclado;

    localparam int unsigned NDIG = 3;
    localparam int unsigned DEB  = 3;
    localparam int unsigned TMO  = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [4:0]        key_code = 5'd16;
    logic              key_act = 1'b0;
    logic [4*NDIG-1:0] buf_bcd;
    logic [3:0]        buf_cnt;
    logic [4*NDIG-1:0] val_bcd;
    logic              val_stb;
    logic [1:0]        cmd;
    logic              cmd_stb;
    logic              ovf;

    int checks = 0;
    int errors = 0;
    int n_val = 0, n_cmd = 0, n_ovf = 0, n_multi = 0;
    int s_val, s_cmd, s_ovf;

    ctrl_entrada_teclado #(.NDIG(NDIG), .DEB(DEB), .TMO(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_code (key_code),
        .key_act  (key_act),
        .buf_bcd  (buf_bcd),
        .buf_cnt  (buf_cnt),
        .val_bcd  (val_bcd),
        .val_stb  (val_stb),
        .cmd      (cmd),
        .cmd_stb  (cmd_stb),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Strobe pulses are tallied mid-cycle, away from the rising edge
    always @(negedge clk) begin
        if (val_stb === 1'b1) n_val++;
        if (cmd_stb === 1'b1) n_cmd++;
        if (ovf === 1'b1) n_ovf++;
        if ((int'(val_stb) + int'(cmd_stb) + int'(ovf)) > 1) n_multi++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_val = n_val;
        s_cmd = n_cmd;
        s_ovf = n_ovf;
    endtask

    task automatic press(input logic [4:0] code, input int hold);
        key_code = code;
        key_act  = 1'b1;
        tick(hold);
        key_act  = 1'b0;
        key_code = 5'd16;
        tick(DEB + 2);
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_buf", 32'(buf_bcd), 32'h0);
        check("rst_cnt", 32'(buf_cnt), 32'h0);
        check("rst_val", 32'(val_bcd), 32'h0);
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_stb", 32'({val_stb, cmd_stb, ovf}), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // 7, 2, Enter
        snap();
        press(5'd7, DEB + 4);
        check("d7_buf", 32'(buf_bcd), 32'h007);
        press(5'd2, DEB + 2);
        check("d2_buf", 32'(buf_bcd), 32'h072);
        check("d2_cnt", 32'(buf_cnt), 32'd2);
        press(5'd14, DEB + 2);
        check("ent_val", 32'(val_bcd), 32'h072);
        check("ent_nstb", 32'(n_val - s_val), 32'd1);
        check("ent_cnt", 32'(buf_cnt), 32'd0);
        check("ent_buf", 32'(buf_bcd), 32'h0);

        // Hold 5 for 50 cycles: single accept
        snap();
        key_code = 5'd5;
        key_act  = 1'b1;
        tick(50);
        check("hold_cnt", 32'(buf_cnt), 32'd1);
        check("hold_buf", 32'(buf_bcd), 32'h005);
        key_act  = 1'b0;
        key_code = 5'd16;
        tick(DEB + 2);
        check("hold_rel_cnt", 32'(buf_cnt), 32'd1);
        press(5'd15, DEB + 2);
        check("clr_cnt", 32'(buf_cnt), 32'd0);

        // Bounce shorter than the debounce window
        key_code = 5'd5;
        for (int i = 0; i < 5; i++) begin
            key_act = 1'b1;
            tick(DEB - 1);
            key_act = 1'b0;
            tick(1);
        end
        key_code = 5'd16;
        tick(DEB + 2);
        check("bounce_cnt", 32'(buf_cnt), 32'd0);

        // Overflow, clear, empty enter
        snap();
        press(5'd1, DEB + 2);
        press(5'd2, DEB + 2);
        press(5'd3, DEB + 2);
        check("full_buf", 32'(buf_bcd), 32'h123);
        check("full_cnt", 32'(buf_cnt), 32'd3);
        check("full_novf", 32'(n_ovf - s_ovf), 32'd0);
        press(5'd4, DEB + 2);
        check("ovf_n", 32'(n_ovf - s_ovf), 32'd1);
        check("ovf_buf", 32'(buf_bcd), 32'h123);
        press(5'd15, DEB + 2);
        check("f_buf", 32'(buf_bcd), 32'h0);
        check("f_cnt", 32'(buf_cnt), 32'd0);
        snap();
        press(5'd14, DEB + 2);
        check("e_empty_nstb", 32'(n_val - s_val), 32'd0);
        check("e_empty_val", 32'(val_bcd), 32'h072);

        // Command key and scan error code
        press(5'd6, DEB + 2);
        snap();
        press(5'd12, DEB + 2);
        check("c_cmd", 32'(cmd), 32'd2);
        check("c_nstb", 32'(n_cmd - s_cmd), 32'd1);
        check("c_buf", 32'(buf_bcd), 32'h006);
        snap();
        press(5'd17, DEB + 2);
        check("err_nstb", 32'(n_val - s_val + n_cmd - s_cmd + n_ovf - s_ovf), 32'd0);
        check("err_buf", 32'(buf_bcd), 32'h006);
        press(5'd15, DEB + 2);
        press(5'd13, DEB + 2);
        check("d_cmd", 32'(cmd), 32'd3);

        // Idle timeout drops a partial entry silently
        snap();
        press(5'd9, DEB + 2);
        check("tmo_pre", 32'(buf_cnt), 32'd1);
        tick(15);
        check("tmo_early", 32'(buf_cnt), 32'd1);
        tick(5);
        check("tmo_cnt", 32'(buf_cnt), 32'd0);
        check("tmo_buf", 32'(buf_bcd), 32'h0);
        check("tmo_nstb", 32'(n_val - s_val), 32'd0);

        // Reset during P_DEB, then key still held after release
        press(5'd4, DEB + 2);
        key_code = 5'd8;
        key_act  = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_buf", 32'(buf_bcd), 32'h0);
        check("mid_rst_cnt", 32'(buf_cnt), 32'd0);
        check("mid_rst_val", 32'(val_bcd), 32'h0);
        check("mid_rst_cmd", 32'(cmd), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(DEB + 1);
        check("post_rst_early", 32'(buf_cnt), 32'd0);
        tick(1);
        check("post_rst_cnt", 32'(buf_cnt), 32'd1);
        check("post_rst_buf", 32'(buf_bcd), 32'h008);
        tick(10);
        check("post_rst_hold", 32'(buf_cnt), 32'd1);
        key_act  = 1'b0;
        key_code = 5'd16;
        tick(DEB + 2);

        check("one_strobe", 32'(n_multi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
